// File: rtl/core_lsu_mem_stage_pkg.sv
// Shared encodings and default widths for the LSU memory/writeback stage.
// Imported by the stage top and its alignment helper.
package core_lsu_mem_stage_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_MEM_ADDR_WIDTH = 10;
    localparam int unsigned DEF_LIS_OP_WIDTH   = 3;
    localparam int unsigned DEF_RD_WIDTH       = 5;

    // lis_op = {unsigned, size[1:0]}
    localparam logic [1:0]  LIS_BYTE     = 2'b00;
    localparam logic [1:0]  LIS_HALF     = 2'b01;
    localparam logic [1:0]  LIS_WORD     = 2'b10;
    localparam int unsigned LIS_UNSIGNED = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/core_lsu_mem_stage_align.sv
// Combinational lane logic: store byte enables, lane replication and misalignment,
// plus load-data shifting with sign/zero extension.
module core_lsu_align
    import core_lsu_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned LIS_OP_WIDTH = DEF_LIS_OP_WIDTH
) (
    input  logic [LIS_OP_WIDTH-1:0] st_lis_op_i,
    input  logic [1:0]              st_addr_lsb_i,
    input  logic [DATA_WIDTH-1:0]   st_wdata_i,
    output logic [3:0]              st_be_o,
    output logic [DATA_WIDTH-1:0]   st_wdata_o,
    output logic                    st_misaligned_o,
    input  logic [LIS_OP_WIDTH-1:0] ld_lis_op_i,
    input  logic [1:0]              ld_addr_lsb_i,
    input  logic [DATA_WIDTH-1:0]   ld_rdata_i,
    output logic [DATA_WIDTH-1:0]   ld_data_o
);

    logic [DATA_WIDTH-1:0] ld_shifted;
    logic                  ld_sign;

    always_comb begin
        st_be_o         = 4'b0000;
        st_wdata_o      = st_wdata_i;
        st_misaligned_o = 1'b0;
        unique case (st_lis_op_i[1:0])
            LIS_BYTE: begin
                st_be_o    = 4'b0001 << st_addr_lsb_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            LIS_HALF: begin
                st_be_o         = 4'b0011 << st_addr_lsb_i;
                st_wdata_o      = {2{st_wdata_i[15:0]}};
                st_misaligned_o = st_addr_lsb_i[0];
            end
            LIS_WORD: begin
                st_be_o         = 4'b1111;
                st_misaligned_o = (st_addr_lsb_i != 2'b00);
            end
            default: st_misaligned_o = 1'b1;
        endcase
    end

    always_comb begin
        ld_shifted = ld_rdata_i >> {ld_addr_lsb_i, 3'b000};
        ld_sign    = 1'b0;
        ld_data_o  = ld_shifted;
        unique case (ld_lis_op_i[1:0])
            LIS_BYTE: begin
                ld_sign   = ~ld_lis_op_i[LIS_UNSIGNED] & ld_shifted[7];
                ld_data_o = {{(DATA_WIDTH-8){ld_sign}}, ld_shifted[7:0]};
            end
            LIS_HALF: begin
                ld_sign   = ~ld_lis_op_i[LIS_UNSIGNED] & ld_shifted[15];
                ld_data_o = {{(DATA_WIDTH-16){ld_sign}}, ld_shifted[15:0]};
            end
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/core_lsu_mem_stage.sv
// Memory-access and writeback stage: runs one OBI-style req/gnt/rvalid transaction per
// load/store and emits exactly one writeback pulse per accepted operation.
module core_lsu_mem_stage
    import core_lsu_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int unsigned LIS_OP_WIDTH   = DEF_LIS_OP_WIDTH,
    parameter int unsigned RD_WIDTH       = DEF_RD_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ex_valid_i,
    output logic                      ex_ready_o,
    input  logic                      ex_is_mem_i,
    input  logic                      ex_is_store_i,
    input  logic [LIS_OP_WIDTH-1:0]   ex_lis_op_i,
    input  logic [MEM_ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [DATA_WIDTH-1:0]     ex_wdata_i,
    input  logic [DATA_WIDTH-1:0]     ex_result_i,
    input  logic [RD_WIDTH-1:0]       ex_rd_i,
    input  logic                      ex_rd_we_i,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    output logic                      data_we_o,
    output logic [3:0]                data_be_o,
    output logic [MEM_ADDR_WIDTH-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i,
    output logic                      wb_valid_o,
    output logic                      wb_we_o,
    output logic [RD_WIDTH-1:0]       wb_rd_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      wb_err_o
);

    logic [1:0]                state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [3:0]                be_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      store_q;
    logic [LIS_OP_WIDTH-1:0]   lis_op_q;
    logic [RD_WIDTH-1:0]       rd_q;
    logic                      rd_we_q;

    logic                      wb_valid_q, wb_we_q, wb_err_q;
    logic [RD_WIDTH-1:0]       wb_rd_q;
    logic [DATA_WIDTH-1:0]     wb_data_q;

    logic                      accept;
    logic [3:0]                st_be;
    logic [DATA_WIDTH-1:0]     st_wdata;
    logic                      st_misaligned;
    logic [DATA_WIDTH-1:0]     ld_data;

    core_lsu_align #(
        .DATA_WIDTH   (DATA_WIDTH),
        .LIS_OP_WIDTH (LIS_OP_WIDTH)
    ) u_align (
        .st_lis_op_i     (ex_lis_op_i),
        .st_addr_lsb_i   (ex_addr_i[1:0]),
        .st_wdata_i      (ex_wdata_i),
        .st_be_o         (st_be),
        .st_wdata_o      (st_wdata),
        .st_misaligned_o (st_misaligned),
        .ld_lis_op_i     (lis_op_q),
        .ld_addr_lsb_i   (addr_q[1:0]),
        .ld_rdata_i      (data_rdata_i),
        .ld_data_o       (ld_data)
    );

    assign ex_ready_o = (state_q == ST_IDLE);
    assign accept     = ex_valid_i && ex_ready_o;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept && ex_is_mem_i && !st_misaligned) state_d = ST_REQ;
            ST_REQ:  if (data_gnt_i) state_d = ST_WAIT;
            ST_WAIT: if (data_rvalid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            lis_op_q   <= '0;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            // Writeback fields are only meaningful during the single-cycle pulse.
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_data_q  <= '0;
            if (state_q == ST_IDLE && accept) begin
                wb_rd_q <= ex_rd_i;
                if (!ex_is_mem_i) begin
                    wb_valid_q <= 1'b1;
                    wb_we_q    <= ex_rd_we_i;
                    wb_data_q  <= ex_result_i;
                end else if (st_misaligned) begin
                    wb_valid_q <= 1'b1;
                    wb_err_q   <= 1'b1;
                end else begin
                    addr_q   <= ex_addr_i;
                    be_q     <= st_be;
                    wdata_q  <= st_wdata;
                    store_q  <= ex_is_store_i;
                    lis_op_q <= ex_lis_op_i;
                    rd_q     <= ex_rd_i;
                    rd_we_q  <= ex_rd_we_i;
                end
            end else if (state_q == ST_WAIT && data_rvalid_i) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= rd_q;
                wb_we_q    <= rd_we_q & ~store_q;
                wb_data_q  <= store_q ? '0 : ld_data;
            end
        end
    end

    assign data_req_o   = (state_q == ST_REQ);
    assign data_we_o    = store_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00};
    assign data_wdata_o = wdata_q;

    assign wb_valid_o = wb_valid_q;
    assign wb_we_o    = wb_we_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign wb_err_o   = wb_err_q;

endmodule

// File: tb/tb_core_lsu_mem_stage.sv
// Directed scoreboard bench for core_lsu_mem_stage: expected writebacks are queued at
// accept time and popped by a negedge monitor whenever wb_valid_o pulses.
module tb_core_lsu_mem_stage;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        err;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, ex_ready_o, ex_is_mem_i, ex_is_store_i;
    logic [2:0]  ex_lis_op_i;
    logic [9:0]  ex_addr_i;
    logic [31:0] ex_wdata_i, ex_result_i;
    logic [4:0]  ex_rd_i;
    logic        ex_rd_we_i;
    logic        data_req_o, data_gnt_i, data_we_o;
    logic [3:0]  data_be_o;
    logic [9:0]  data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        wb_valid_o, wb_we_o, wb_err_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    wb_exp_t sb[$];
    int      vectors = 0;
    int      miscompares = 0;

    always #5 clk = ~clk;

    core_lsu_mem_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .ex_valid_i    (ex_valid_i),
        .ex_ready_o    (ex_ready_o),
        .ex_is_mem_i   (ex_is_mem_i),
        .ex_is_store_i (ex_is_store_i),
        .ex_lis_op_i   (ex_lis_op_i),
        .ex_addr_i     (ex_addr_i),
        .ex_wdata_i    (ex_wdata_i),
        .ex_result_i   (ex_result_i),
        .ex_rd_i       (ex_rd_i),
        .ex_rd_we_i    (ex_rd_we_i),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_addr_o   (data_addr_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .wb_we_o       (wb_we_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o),
        .wb_err_o      (wb_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every writeback pulse must match the oldest expectation.
    always @(negedge clk) begin
        wb_exp_t e;
        if (wb_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_wb", {31'b0, wb_valid_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wb_rd",   {27'b0, wb_rd_o}, {27'b0, e.rd});
                check("wb_we",   {31'b0, wb_we_o}, {31'b0, e.we});
                check("wb_data", wb_data_o, e.data);
                check("wb_err",  {31'b0, wb_err_o}, {31'b0, e.err});
            end
        end
    end

    // One memory operation with programmable gnt/rvalid delays. A bogus rvalid is driven
    // in the grant cycle; it must not be taken as the response.
    task automatic mem_op(input logic store, input logic [2:0] op, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int gnt_dly,
                          input int rv_dly, input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
        ex_valid_i = 1'b1; ex_is_mem_i = 1'b1; ex_is_store_i = store;
        ex_lis_op_i = op; ex_addr_i = addr; ex_wdata_i = wdata; ex_rd_i = rd;
        ex_rd_we_i = 1'b1; ex_result_i = 32'h5555_AAAA;
        sb.push_back('{rd: rd, we: !store, data: store ? 32'd0 : exp_wb, err: 1'b0});
        tick();
        ex_valid_i = 1'b0;
        for (int i = 0; i <= gnt_dly; i++) begin
            check("req_high",  {31'b0, data_req_o}, 32'd1);
            check("req_addr",  {22'b0, data_addr_o}, {22'b0, addr[9:2], 2'b00});
            check("req_be",    {28'b0, data_be_o}, {28'b0, exp_be});
            check("req_we",    {31'b0, data_we_o}, {31'b0, store});
            check("req_wdata", data_wdata_o, exp_wdata);
            check("busy_ready", {31'b0, ex_ready_o}, 32'd0);
            if (i == gnt_dly) begin
                data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = ~rdata;
            end
            tick();
        end
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        for (int i = 0; i < rv_dly; i++) begin
            check("wait_req_low", {31'b0, data_req_o}, 32'd0);
            tick();
            check("wait_no_wb", {31'b0, wb_valid_o}, 32'd0);
        end
        check("wait_req_low", {31'b0, data_req_o}, 32'd0);
        data_rvalid_i = 1'b1; data_rdata_i = rdata;
        tick();
        data_rvalid_i = 1'b0;
        check("mem_wb_pulse", {31'b0, wb_valid_o}, 32'd1);
        check("mem_ready_back", {31'b0, ex_ready_o}, 32'd1);
    endtask

    initial begin
        rst_i = 1'b1; ex_valid_i = 1'b0; ex_is_mem_i = 1'b0; ex_is_store_i = 1'b0;
        ex_lis_op_i = '0; ex_addr_i = '0; ex_wdata_i = '0; ex_result_i = '0;
        ex_rd_i = '0; ex_rd_we_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        data_rdata_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_ready",    {31'b0, ex_ready_o}, 32'd1);
        check("rst_req",      {31'b0, data_req_o}, 32'd0);
        check("rst_be",       {28'b0, data_be_o}, 32'd0);
        check("rst_addr",     {22'b0, data_addr_o}, 32'd0);
        check("rst_wdata",    data_wdata_o, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
        check("rst_wb_data",  wb_data_o, 32'd0);

        // Three back-to-back non-memory ops.
        ex_valid_i = 1'b1; ex_is_mem_i = 1'b0;
        ex_result_i = 32'h1234_5678; ex_rd_i = 5'd5; ex_rd_we_i = 1'b1;
        sb.push_back('{rd: 5'd5, we: 1'b1, data: 32'h1234_5678, err: 1'b0});
        tick();
        check("nonmem_pulse0", {31'b0, wb_valid_o}, 32'd1);
        ex_result_i = 32'hA5A5_0001; ex_rd_i = 5'd6;
        sb.push_back('{rd: 5'd6, we: 1'b1, data: 32'hA5A5_0001, err: 1'b0});
        tick();
        check("nonmem_pulse1", {31'b0, wb_valid_o}, 32'd1);
        ex_result_i = 32'h0000_00FF; ex_rd_i = 5'd7; ex_rd_we_i = 1'b0;
        sb.push_back('{rd: 5'd7, we: 1'b0, data: 32'h0000_00FF, err: 1'b0});
        tick();
        check("nonmem_pulse2", {31'b0, wb_valid_o}, 32'd1);
        ex_valid_i = 1'b0;
        tick();
        check("nonmem_idle", {31'b0, wb_valid_o}, 32'd0);

        // Byte loads at addr 3, signed then unsigned, earliest gnt/rvalid.
        mem_op(1'b0, 3'b000, 10'h003, 32'h0, 5'd8, 0, 0, 32'h80FF_FF01, 4'b1000,
               32'h0, 32'hFFFF_FF80);
        mem_op(1'b0, 3'b100, 10'h003, 32'h0, 5'd9, 0, 0, 32'h80FF_FF01, 4'b1000,
               32'h0, 32'h0000_0080);
        // Half store at addr 2 with a 3-cycle grant delay.
        mem_op(1'b1, 3'b001, 10'h002, 32'hDEAD_BEEF, 5'd10, 3, 1, 32'h0, 4'b1100,
               32'hBEEF_BEEF, 32'h0);
        // Byte store at addr 1.
        mem_op(1'b1, 3'b000, 10'h001, 32'h0000_00A5, 5'd11, 0, 0, 32'h0, 4'b0010,
               32'hA5A5_A5A5, 32'h0);
        // Signed half load at addr 0x3FE, word load at addr 0x004 with delays.
        mem_op(1'b0, 3'b001, 10'h3FE, 32'h0, 5'd12, 1, 0, 32'h8001_1234, 4'b1100,
               32'h0, 32'hFFFF_8001);
        mem_op(1'b0, 3'b010, 10'h004, 32'h0, 5'd13, 2, 2, 32'hCAFE_F00D, 4'b1111,
               32'h0, 32'hCAFE_F00D);

        // Misaligned word load: error writeback, no bus request.
        ex_valid_i = 1'b1; ex_is_mem_i = 1'b1; ex_is_store_i = 1'b0;
        ex_lis_op_i = 3'b010; ex_addr_i = 10'h001; ex_rd_i = 5'd14; ex_rd_we_i = 1'b1;
        sb.push_back('{rd: 5'd14, we: 1'b0, data: 32'h0, err: 1'b1});
        tick();
        // Misaligned half store straight after.
        ex_is_store_i = 1'b1; ex_lis_op_i = 3'b001; ex_addr_i = 10'h003; ex_rd_i = 5'd15;
        sb.push_back('{rd: 5'd15, we: 1'b0, data: 32'h0, err: 1'b1});
        check("misal_no_req", {31'b0, data_req_o}, 32'd0);
        check("misal_pulse",  {31'b0, wb_valid_o}, 32'd1);
        tick();
        ex_valid_i = 1'b0;
        check("misal2_no_req", {31'b0, data_req_o}, 32'd0);
        check("misal2_pulse",  {31'b0, wb_valid_o}, 32'd1);
        check("misal_ready",   {31'b0, ex_ready_o}, 32'd1);
        tick();

        // Reset while waiting for rvalid; the late response must be ignored.
        ex_valid_i = 1'b1; ex_is_store_i = 1'b0; ex_lis_op_i = 3'b010;
        ex_addr_i = 10'h010; ex_rd_i = 5'd16;
        tick();
        ex_valid_i = 1'b0; data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        check("rstw_in_wait", {31'b0, data_req_o}, 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstw_ready", {31'b0, ex_ready_o}, 32'd1);
        check("rstw_addr",  {22'b0, data_addr_o}, 32'd0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_2222;
        tick();
        data_rvalid_i = 1'b0;
        check("rstw_no_wb", {31'b0, wb_valid_o}, 32'd0);
        check("rstw_idle",  {31'b0, ex_ready_o}, 32'd1);

        // Spurious rvalid and gnt in IDLE.
        data_rvalid_i = 1'b1; data_gnt_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0; data_gnt_i = 1'b0;
        check("spur_no_wb",  {31'b0, wb_valid_o}, 32'd0);
        check("spur_no_req", {31'b0, data_req_o}, 32'd0);
        check("spur_ready",  {31'b0, ex_ready_o}, 32'd1);

        tick();
        tick();
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_lsu_mem_stage.md
Name: core_lsu_mem_stage

Overview:
- Memory-access and writeback stage, directly downstream of the execution unit.
- Accepts one operation per handshake: ALU result, LIS opcode, data address and store data, driven by the execution unit.
- Loads/stores run a request/grant/rvalid (OBI-style) transaction on the data port.
- Loaded data is aligned and extended; one writeback pulse per operation goes to the register file.

Parameters:
- DATA_WIDTH, 32, register/data width; only 32 supported.
- MEM_ADDR_WIDTH, 10, byte-address width of the data port.
- LIS_OP_WIDTH, 3, LIS opcode width.
- RD_WIDTH, 5, destination register index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ex_valid_i  in  1  execute stage presents an operation.
- ex_ready_o  out  1  stage can accept; high only in IDLE.
- ex_is_mem_i  in  1  operation is a load or store.
- ex_is_store_i  in  1  store (valid only with ex_is_mem_i).
- ex_lis_op_i  in  LIS_OP_WIDTH  {unsigned, size[1:0]}; size 00=byte, 01=half, 10=word.
- ex_addr_i  in  MEM_ADDR_WIDTH  byte address from the execution unit.
- ex_wdata_i  in  DATA_WIDTH  raw store data (rs2).
- ex_result_i  in  DATA_WIDTH  ALU/CSR/link result for non-memory ops.
- ex_rd_i  in  RD_WIDTH  destination register.
- ex_rd_we_i  in  1  operation writes rd.
- data_req_o  out  1  data request.
- data_gnt_i  in  1  request accepted.
- data_we_o  out  1  write request.
- data_be_o  out  4  byte enables.
- data_addr_o  out  MEM_ADDR_WIDTH  word-aligned address ({addr[MSB:2],2'b00}).
- data_wdata_o  out  DATA_WIDTH  lane-replicated store data.
- data_rvalid_i  in  1  response valid.
- data_rdata_i  in  DATA_WIDTH  response data.
- wb_valid_o  out  1  one-cycle writeback pulse.
- wb_we_o  out  1  register file write enable (qualified by wb_valid_o).
- wb_rd_o  out  RD_WIDTH  destination register.
- wb_data_o  out  DATA_WIDTH  writeback data.
- wb_err_o  out  1  misaligned access, valid with wb_valid_o.

Behaviour:

Reset:
- State IDLE.
- All data_* and wb_* outputs are 0.
- ex_ready_o is 1 in the first cycle after rst_i deasserts.

FSM states and transitions:
- IDLE:
  - Accept when ex_valid_i && ex_ready_o.
  - Non-mem op: wb_valid_o=1 the next cycle with wb_data_o=ex_result_i, wb_we_o=ex_rd_we_i, wb_err_o=0. Latency 1. Stay IDLE; back-to-back accepts allowed every cycle.
  - Misaligned mem op (half with addr[0]=1, word with addr[1:0]!=0, size 11): no bus request. Next cycle wb_valid_o=1, wb_err_o=1, wb_we_o=0, wb_data_o=0. Stay IDLE.
  - Aligned mem op: latch addr, be, wdata, lis_op, rd, rd_we → REQ.
- REQ:
  - data_req_o=1; data_addr_o, data_be_o, data_we_o, data_wdata_o held stable until data_gnt_i.
  - On data_gnt_i → WAIT; data_req_o drops the following cycle.
- WAIT:
  - data_req_o=0; wait for data_rvalid_i.
  - On data_rvalid_i: next cycle wb_valid_o=1, wb_err_o=0 → IDLE.
  - Load: wb_we_o=rd_we and wb_data_o = extracted data.
  - Store: wb_we_o=0 and wb_data_o=0.
- Minimum load/store latency (gnt and rvalid each arriving on the earliest cycle): accept(c0), req(c1, gnt c1), rvalid(c2), wb_valid(c3).

Byte enables and store data:
- Byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
- Half: be = 4'b0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
- Word: be = 4'b1111; wdata unchanged.

Load extraction:
- shifted = rdata >> (8*addr[1:0]).
- Byte/half are sign-extended unless lis_op[2]=1 (zero-extended).

Boundary cases:
- data_rvalid_i outside WAIT is ignored.
- data_gnt_i outside REQ is ignored.
- rvalid in the same cycle as gnt is not counted; the response must arrive in WAIT.
- ex_valid_i while ex_ready_o=0 is not consumed; upstream holds it.
- rst_i mid-transaction aborts to IDLE and clears outputs. A late rvalid after reset is ignored per the rule above.
- No writeback backpressure; wb_valid_o is always a single-cycle pulse.

Decomposition:
- Shared package/defines:
  - LIS size encodings (LIS_BYTE=2'b00, LIS_HALF=2'b01, LIS_WORD=2'b10) and LIS_UNSIGNED bit index.
  - FSM state encodings (IDLE=0, REQ=1, WAIT=2).
  - Default widths.
- One natural sub-module: core_lsu_align, purely combinational.
  - Store path: be/wdata generation and misalignment flag.
  - Load path: shift and sign/zero extension.
  - The top keeps the FSM and the registers.

Test Plan:
- Non-mem op: ex_result_i=0x12345678, rd=5, rd_we=1 → next cycle wb_valid_o=1, wb_rd_o=5, wb_data_o=0x12345678, wb_we_o=1; accept on every cycle for 3 ops → 3 consecutive wb pulses.
- Signed byte load: addr=0x003, gnt immediate, rdata=0x80FF_FF01 on rvalid → data_be_o=4'b1000, data_addr_o=0x000, wb_data_o=0xFFFFFF80; same with lis_op[2]=1 → 0x00000080.
- Half store: addr=0x002, wdata=0xDEADBEEF, gnt delayed 3 cycles → data_req_o held high 4 cycles with stable addr 0x000, be=4'b1100, wdata=0xBEEFBEEF; after rvalid, wb_valid_o=1 with wb_we_o=0.
- Misaligned word load: addr=0x001 → no data_req_o; next cycle wb_valid_o=1, wb_err_o=1, wb_we_o=0.
- Reset in WAIT: assert rst_i one cycle, then rvalid arrives → no wb_valid_o, state IDLE, ex_ready_o=1.
- Spurious rvalid in IDLE with no op pending → no wb_valid_o, no state change.
